// File: rtl/fe_pkg.sv
// Shared constants, state encoding and modular helpers
// for the GF(2^255-19) multiplier arbiter.
package fe_pkg;

  localparam int FE_WIDTH = 255;

  localparam logic [FE_WIDTH-1:0] P =
    {FE_WIDTH{1'b1}} - 255'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FLUSH
  } arb_state_t;

  // Inputs may exceed P by at most 18, so one subtraction suffices.
  function automatic logic [FE_WIDTH-1:0] fe_reduce(
    input logic [FE_WIDTH-1:0] x
  );
    return (x >= P) ? x - P : x;
  endfunction

  function automatic logic [FE_WIDTH-1:0] fe_dbl_add(
    input logic [FE_WIDTH-1:0] acc,
    input logic [FE_WIDTH-1:0] a,
    input logic                add
  );
    logic [FE_WIDTH:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, P}) t = t - {1'b0, P};
    if (add) t = t + {1'b0, a};
    if (t >= {1'b0, P}) t = t - {1'b0, P};
    return t[FE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/femul.sv
// Bit-serial MSB-first field multiplier, one operand bit per cycle.
// Deliberately reset-free; a run cut short by system reset still completes.
module femul
  import fe_pkg::*;
(
  input  logic                clock,
  input  logic                start,
  input  logic [FE_WIDTH-1:0] a_in,
  input  logic [FE_WIDTH-1:0] b_in,
  output logic                done,
  output logic [FE_WIDTH-1:0] product
);

  logic [FE_WIDTH-1:0] a_q;
  logic [FE_WIDTH-1:0] b_q;
  logic [FE_WIDTH-1:0] acc;
  logic [7:0]          cnt;
  logic                run;

  always_ff @(posedge clock) begin
    done <= 1'b0;
    if (start) begin
      a_q <= fe_reduce(a_in);
      b_q <= b_in;
      acc <= '0;
      cnt <= 8'd254;
      run <= 1'b1;
    end else if (run) begin
      acc <= fe_dbl_add(acc, a_q, b_q[FE_WIDTH-1]);
      b_q <= {b_q[FE_WIDTH-2:0], 1'b0};
      cnt <= cnt - 8'd1;
      if (cnt == 8'd0) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/femul_arbiter.sv
// Two-requester round-robin front end for a single field multiplier,
// with a flush path that drains a multiply orphaned by reset.
module femul_arbiter
  import fe_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_start,
  input  logic [FE_WIDTH-1:0] req0_a,
  input  logic [FE_WIDTH-1:0] req0_b,
  output logic                req0_done,
  input  logic                req1_start,
  input  logic [FE_WIDTH-1:0] req1_a,
  input  logic [FE_WIDTH-1:0] req1_b,
  output logic                req1_done,
  output logic [FE_WIDTH-1:0] prod_out,
  output logic                busy,
  output logic                overrun
);

  arb_state_t          state;
  arb_state_t          state_nx;
  logic [1:0]          pending;
  logic [1:0]          done_q;
  logic [FE_WIDTH-1:0] buf_a [2];
  logic [FE_WIDTH-1:0] buf_b [2];
  logic [FE_WIDTH-1:0] op_a;
  logic [FE_WIDTH-1:0] op_b;
  logic [FE_WIDTH-1:0] fe_prod;
  logic                grant;
  logic                grant_nx;
  logic                last_grant;
  logic                flush;
  logic                stale;
  logic                fe_start;
  logic                fe_done;

  assign fe_start  = (state == S_ISSUE);
  assign req0_done = done_q[0];
  assign req1_done = done_q[1];
  assign busy      = (state != S_IDLE) || flush;

  // A result still owed by femul at reset must be swallowed later.
  assign stale = (state == S_ISSUE)
              || ((state == S_WAIT || state == S_FLUSH) && !fe_done)
              || (flush && state == S_IDLE);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    unique case (state)
      S_IDLE: begin
        if (flush) begin
          state_nx = S_FLUSH;
        end else if (|pending) begin
          state_nx = S_ISSUE;
          grant_nx = (&pending) ? ~last_grant : pending[1];
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (fe_done) state_nx = S_IDLE;
      S_FLUSH: if (fe_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      pending    <= '0;
      done_q     <= '0;
      overrun    <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      prod_out   <= '0;
      flush      <= stale;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      done_q <= '0;
      if (state == S_IDLE && state_nx == S_ISSUE) begin
        op_a       <= buf_a[grant_nx];
        op_b       <= buf_b[grant_nx];
        last_grant <= grant_nx;
      end
      if (state == S_WAIT && fe_done) begin
        prod_out       <= fe_prod;
        done_q[grant]  <= 1'b1;
        pending[grant] <= 1'b0;
      end
      if (state == S_FLUSH && fe_done) flush <= 1'b0;
      if (req0_start) begin
        if (pending[0]) begin
          overrun <= 1'b1;
        end else begin
          pending[0] <= 1'b1;
          buf_a[0]   <= req0_a;
          buf_b[0]   <= req0_b;
        end
      end
      if (req1_start) begin
        if (pending[1]) begin
          overrun <= 1'b1;
        end else begin
          pending[1] <= 1'b1;
          buf_a[1]   <= req1_a;
          buf_b[1]   <= req1_b;
        end
      end
    end
  end

  femul u_femul (
    .clock   (clock),
    .start   (fe_start),
    .a_in    (op_a),
    .b_in    (op_b),
    .done    (fe_done),
    .product (fe_prod)
  );

endmodule

// File: tb/tb_femul_arbiter.sv
// Scenario bench for femul_arbiter; products checked against
// a wide-integer a*b mod (2^255-19) reference.
module tb_femul_arbiter;

  localparam logic [255:0] P_TB =
    (256'd1 << 255) - 256'd19;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0_start = 1'b0;
  logic [254:0] req0_a = '0;
  logic [254:0] req0_b = '0;
  logic         req0_done;
  logic         req1_start = 1'b0;
  logic [254:0] req1_a = '0;
  logic [254:0] req1_b = '0;
  logic         req1_done;
  logic [254:0] prod_out;
  logic         busy;
  logic         overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit           dq_id[$];
  logic [254:0] dq_val[$];
  int           dq_cyc[$];
  int           fs_cyc[$];
  int           fd_cyc[$];

  femul_arbiter u_dut (
    .clock      (clock),
    .reset      (reset),
    .req0_start (req0_start),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_done  (req0_done),
    .req1_start (req1_start),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_done  (req1_done),
    .prod_out   (prod_out),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (req0_done) begin
      dq_id.push_back(1'b0);
      dq_val.push_back(prod_out);
      dq_cyc.push_back(cyc);
    end
    if (req1_done) begin
      dq_id.push_back(1'b1);
      dq_val.push_back(prod_out);
      dq_cyc.push_back(cyc);
    end
    if (u_dut.fe_start) fs_cyc.push_back(cyc);
    if (u_dut.fe_done) fd_cyc.push_back(cyc);
  end

  function automatic logic [254:0] ref_mul(
    input logic [254:0] a,
    input logic [254:0] b
  );
    logic [511:0] x;
    x = {257'd0, a} * {257'd0, b};
    x = x % {256'd0, P_TB};
    return x[254:0];
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0: r = P_TB - 256'($urandom_range(1, 20));
      1: r = P_TB + 256'($urandom_range(0, 17));
      default: ;
    endcase
    return r[254:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    dq_id.delete();
    dq_val.delete();
    dq_cyc.delete();
    fs_cyc.delete();
    fd_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_start = 1'b0;
    req1_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    clear_q();
  endtask

  task automatic issue(
    input logic [1:0]   m,
    input logic [254:0] a0,
    input logic [254:0] b0,
    input logic [254:0] a1,
    input logic [254:0] b1
  );
    req0_start = m[0];
    req0_a = a0;
    req0_b = b0;
    req1_start = m[1];
    req1_a = a1;
    req1_b = b1;
    tick();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_dones(input int k, output bit ok);
    int t = 0;
    while (dq_id.size() < k && t < 3000) begin
      tick();
      t++;
    end
    ok = (dq_id.size() >= k);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (prod_out !== '0) begin
      n_err++;
      $display("FAIL reset_prod: got %h want 0", prod_out);
    end
    n_vec++;
    if (req0_done !== 1'b0 || req1_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b%b want 00",
               req1_done, req0_done);
    end
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    int t0;
    int fs;
    int fd;
    do_reset();
    t0 = cyc;
    issue(2'b01, 255'd3, 255'd5, '0, '0);
    wait_dones(1, ok);
    repeat (40) tick();
    fs = (fs_cyc.size() > 0) ? fs_cyc[0] : -1;
    fd = (fd_cyc.size() > 0) ? fd_cyc[0] : -1;
    n_vec++;
    if (fs != t0 + 2) begin
      n_err++;
      $display("FAIL single_start_lat: got cycle %0d want %0d",
               fs, t0 + 2);
    end
    n_vec++;
    if (dq_id.size() != 1) begin
      n_err++;
      $display("FAIL single_count: got %0d dones want 1",
               dq_id.size());
    end
    if (ok) begin
      n_vec++;
      if (dq_id[0] !== 1'b0 || dq_val[0] !== 255'd15) begin
        n_err++;
        $display("FAIL single_result: got id %0d val %0d want 0/15",
                 dq_id[0], dq_val[0]);
      end
      n_vec++;
      if (dq_cyc[0] != fd + 1) begin
        n_err++;
        $display("FAIL single_done_lat: got cycle %0d want %0d",
                 dq_cyc[0], fd + 1);
      end
    end
    n_vec++;
    if (prod_out !== 255'd15) begin
      n_err++;
      $display("FAIL single_hold: got %0d want 15", prod_out);
    end
  endtask

  task automatic test_idle_reset();
    do_reset();
    n_vec++;
    if (busy !== 1'b0 || prod_out !== '0) begin
      n_err++;
      $display("FAIL idle_reset: got busy %b prod %0d want 0/0",
               busy, prod_out);
    end
  endtask

  task automatic test_tie();
    bit ok;
    logic [255:0] pt;
    logic [254:0] pm1;
    logic [254:0] big;
    pt = P_TB;
    pm1 = pt[254:0] - 255'd1;
    big = 255'd1 << 254;
    do_reset();
    issue(2'b11, pm1, pm1, 255'd2, big);
    wait_dones(2, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL tie_timeout: got %0d dones want 2",
               dq_id.size());
    end else begin
      n_vec++;
      if (dq_id[0] !== 1'b0 || dq_val[0] !== 255'd1) begin
        n_err++;
        $display("FAIL tie_first: got id %0d val %0d want 0/1",
                 dq_id[0], dq_val[0]);
      end
      n_vec++;
      if (dq_id[1] !== 1'b1 || dq_val[1] !== 255'd19) begin
        n_err++;
        $display("FAIL tie_second: got id %0d val %0d want 1/19",
                 dq_id[1], dq_val[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [254:0] e0[$];
    logic [254:0] e1[$];
    logic [254:0] a0, b0, a1, b1, ex;
    bit id;
    bit expid;
    int issued, got, t;
    do_reset();
    a0 = rnd255(); b0 = rnd255();
    a1 = rnd255(); b1 = rnd255();
    e0.push_back(ref_mul(a0, b0));
    e1.push_back(ref_mul(a1, b1));
    issue(2'b11, a0, b0, a1, b1);
    issued = 2; got = 0; t = 0; expid = 1'b0;
    while (got < 8 && t < 6000) begin
      if (req0_done || req1_done) begin
        id = req1_done;
        n_vec++;
        if (id !== expid) begin
          n_err++;
          $display("FAIL b2b_grant%0d: got %0d want %0d",
                   got, id, expid);
        end
        if (id) ex = (e1.size() > 0) ? e1.pop_front() : '0;
        else    ex = (e0.size() > 0) ? e0.pop_front() : '0;
        n_vec++;
        if (prod_out !== ex) begin
          n_err++;
          $display("FAIL b2b_value%0d: got %h want %h",
                   got, prod_out, ex);
        end
        got++;
        expid = !expid;
        if (issued < 8) begin
          a0 = rnd255(); b0 = rnd255();
          if (id) e1.push_back(ref_mul(a0, b0));
          else    e0.push_back(ref_mul(a0, b0));
          issue(id ? 2'b10 : 2'b01, a0, b0, a0, b0);
          issued++;
          t++;
          continue;
        end
      end
      tick();
      t++;
    end
    n_vec++;
    if (got != 8) begin
      n_err++;
      $display("FAIL b2b_timeout: got %0d dones want 8", got);
    end
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [254:0] a, b, a2, b2, ex;
    do_reset();
    a = rnd255(); b = rnd255();
    a2 = rnd255(); b2 = rnd255();
    ex = ref_mul(a, b);
    issue(2'b10, '0, '0, a, b);
    repeat (10) tick();
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_early: got %b want 0", overrun);
    end
    issue(2'b10, '0, '0, a2, b2);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set: got %b want 1", overrun);
    end
    wait_dones(1, ok);
    repeat (300) tick();
    n_vec++;
    if (dq_id.size() != 1) begin
      n_err++;
      $display("FAIL ovr_count: got %0d dones want 1",
               dq_id.size());
    end
    if (ok) begin
      n_vec++;
      if (dq_id[0] !== 1'b1 || dq_val[0] !== ex) begin
        n_err++;
        $display("FAIL ovr_result: got id %0d val %h want 1/%h",
                 dq_id[0], dq_val[0], ex);
      end
    end
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int t;
    logic [254:0] a, b, a2, b2;
    do_reset();
    a = rnd255(); b = rnd255();
    a2 = rnd255(); b2 = rnd255();
    issue(2'b01, a, b, '0, '0);
    t = 0;
    while (!req0_done && t < 3000) begin
      tick();
      t++;
    end
    n_vec++;
    if (req0_done !== 1'b1) begin
      n_err++;
      $display("FAIL same_first: got done %b want 1", req0_done);
    end
    issue(2'b01, a2, b2, '0, '0);
    wait_dones(2, ok);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL same_overrun: got %b want 0", overrun);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL same_timeout: got %0d dones want 2",
               dq_id.size());
    end else if (dq_val[0] !== ref_mul(a, b)
              || dq_val[1] !== ref_mul(a2, b2)) begin
      n_err++;
      $display("FAIL same_values: got %h %h want %h %h",
               dq_val[0], dq_val[1], ref_mul(a, b), ref_mul(a2, b2));
    end
  endtask

  task automatic test_flush();
    bit ok;
    int fd1;
    do_reset();
    issue(2'b01, rnd255(), rnd255(), '0, '0);
    repeat (20) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || prod_out !== '0) begin
      n_err++;
      $display("FAIL flush_entry: got busy %b prod %0d want 1/0",
               busy, prod_out);
    end
    issue(2'b01, 255'd7, 255'd11, '0, '0);
    wait_dones(1, ok);
    repeat (20) tick();
    n_vec++;
    if (dq_id.size() != 1) begin
      n_err++;
      $display("FAIL flush_count: got %0d dones want 1",
               dq_id.size());
    end
    if (ok) begin
      n_vec++;
      if (dq_id[0] !== 1'b0 || dq_val[0] !== 255'd77) begin
        n_err++;
        $display("FAIL flush_result: got id %0d val %0d want 0/77",
                 dq_id[0], dq_val[0]);
      end
      fd1 = (fd_cyc.size() > 1) ? fd_cyc[1] : -1;
      n_vec++;
      if (fd_cyc.size() != 2 || dq_cyc[0] != fd1 + 1) begin
        n_err++;
        $display("FAIL flush_stale: got %0d femul dones, done at %0d want 2, %0d",
                 fd_cyc.size(), dq_cyc[0], fd1 + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [254:0] e0[$];
    logic [254:0] e1[$];
    logic [254:0] ex;
    bit pend0, pend1;
    int issued, t;
    do_reset();
    pend0 = 0; pend1 = 0; issued = 0; t = 0;
    while ((issued < 16 || pend0 || pend1) && t < 20000) begin
      req0_start = 1'b0;
      req1_start = 1'b0;
      if (req0_done) begin
        ex = (e0.size() > 0) ? e0.pop_front() : '0;
        n_vec++;
        if (prod_out !== ex || !pend0) begin
          n_err++;
          $display("FAIL rand_r0: got %h want %h", prod_out, ex);
        end
        pend0 = 0;
      end
      if (req1_done) begin
        ex = (e1.size() > 0) ? e1.pop_front() : '0;
        n_vec++;
        if (prod_out !== ex || !pend1) begin
          n_err++;
          $display("FAIL rand_r1: got %h want %h", prod_out, ex);
        end
        pend1 = 0;
      end
      if (!pend0 && issued < 16 && $urandom_range(0, 15) == 0) begin
        req0_a = rnd255();
        req0_b = rnd255();
        req0_start = 1'b1;
        e0.push_back(ref_mul(req0_a, req0_b));
        pend0 = 1;
        issued++;
      end
      if (!pend1 && issued < 16 && $urandom_range(0, 15) == 0) begin
        req1_a = rnd255();
        req1_b = rnd255();
        req1_start = 1'b1;
        e1.push_back(ref_mul(req1_a, req1_b));
        pend1 = 1;
        issued++;
      end
      tick();
      t++;
    end
    req0_start = 1'b0;
    req1_start = 1'b0;
    n_vec++;
    if (pend0 || pend1 || issued < 16) begin
      n_err++;
      $display("FAIL rand_timeout: got %0d issued, pending %b%b",
               issued, pend1, pend0);
    end
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL rand_overrun: got %b want 0", overrun);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_idle_reset();
    test_tie();
    test_back_to_back();
    test_overrun();
    test_same_cycle();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
